// File: rtl/alu_operand_loader_pkg.sv
// Shared definitions for the operand-entry stage
// and the ALU stages that consume its opcode.
package alu_operand_loader_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int OP_W_DEF  = 3;

  typedef enum logic [1:0] {
    GET_A   = 2'd0,
    GET_B   = 2'd1,
    GET_OP  = 2'd2,
    PRESENT = 2'd3
  } state_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;

endpackage

// File: rtl/alu_operand_loader_btn_debouncer.sv
// Push-button conditioner: 2-flop sync, stability
// counter, debounced level and one-cycle press pulse.
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          pulse_q, pulse_d;
  logic [1:0]    fill_q;
  logic          armed_q, armed_d;

  // A press is only honoured once a released level has been
  // seen after reset, so a button held through reset stays silent.
  always_comb begin
    cnt_d   = '0;
    lvl_d   = lvl_q;
    pulse_d = 1'b0;
    armed_d = armed_q | (fill_q[1] & ~s2_q);
    if (s2_q != lvl_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        lvl_d   = ~lvl_q;
        pulse_d = ~lvl_q & armed_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      pulse_q <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      pulse_q <= pulse_d;
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Operand entry: A, B, opcode from switches, then
// held stable for the ALU under valid/ready.
module alu_operand_loader
  import alu_operand_loader_pkg::*;
#(
  parameter int WIDTH           = WIDTH_DEF,
  parameter int OP_W            = OP_W_DEF,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_data,
  input  logic [OP_W-1:0]  sw_op,
  input  logic             btn_load,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [OP_W-1:0]  opcode,
  output logic             valid,
  input  logic             ready,
  output logic [1:0]       state_dbg
);

  logic ld_p, clr_p;

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_load (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_load),
    .pulse_o(ld_p)
  );

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_clear (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_clear),
    .pulse_o(clr_p)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = valid_q;
    // Clear outranks both a load and a pending handshake.
    if (clr_p) begin
      state_d = GET_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        GET_A: if (ld_p) begin
          a_d     = sw_data;
          state_d = GET_B;
        end
        GET_B: if (ld_p) begin
          b_d     = sw_data;
          state_d = GET_OP;
        end
        GET_OP: if (ld_p) begin
          op_d    = sw_op;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
        PRESENT: if (valid_q && ready) begin
          valid_d = 1'b0;
          state_d = GET_A;
        end
        default: state_d = GET_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
    end
  end

  assign op_a      = a_q;
  assign op_b      = b_q;
  assign opcode    = op_q;
  assign valid     = valid_q;
  assign state_dbg = state_q;

endmodule
